// File: rtl/d_ff_pkg.sv
// Shared constants and width helpers for the d_ff_pipe delay line.
package d_ff_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultDepth = 4;

    // Tap select is kept at least one bit wide so a single-stage pipe still has a legal port.
    function automatic int unsigned tap_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/d_ff_pipe_if.sv
// Bus bundle for d_ff_pipe; the clr signal exists only with D_FF_PIPE_CLR_EN defined.
interface d_ff_pipe_if
    import d_ff_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth
) ();

    localparam int unsigned TapW = tap_w(DEPTH);
    localparam int unsigned CntW = cnt_w(DEPTH);

    logic             en;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [TapW-1:0]  tap_sel;
    logic [WIDTH-1:0] tap_q;
    logic             tap_valid;
    logic [CntW-1:0]  count;
`ifdef D_FF_PIPE_CLR_EN
    logic             clr;

    modport master (
        output en, d, d_valid, tap_sel, clr,
        input  q, q_valid, tap_q, tap_valid, count
    );
    modport slave (
        input  en, d, d_valid, tap_sel, clr,
        output q, q_valid, tap_q, tap_valid, count
    );
`else
    modport master (
        output en, d, d_valid, tap_sel,
        input  q, q_valid, tap_q, tap_valid, count
    );
    modport slave (
        input  en, d, d_valid, tap_sel,
        output q, q_valid, tap_q, tap_valid, count
    );
`endif

endinterface

// File: rtl/d_ff_stage.sv
// One {data, valid} register of the pipe: async reset, synchronous clear over enable.
module d_ff_stage #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en_i,
    input  logic           clr_i,
    input  logic [WIDTH:0] d_i,
    output logic [WIDTH:0] q_o
);

    logic [WIDTH:0] stage_d, stage_q;

    always_comb begin
        stage_d = stage_q;
        if (clr_i) begin
            stage_d = {RST_VAL, 1'b0};
        end else if (en_i) begin
            stage_d = d_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= {RST_VAL, 1'b0};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q;

endmodule

// File: rtl/d_ff_pipe.sv
// DEPTH-stage data/valid delay line with occupancy count and selectable tap.
// Optional synchronous clear enabled by defining D_FF_PIPE_CLR_EN.
module d_ff_pipe
    import d_ff_pkg::*;
#(
    parameter int unsigned      WIDTH   = DefaultWidth,
    parameter int unsigned      DEPTH   = DefaultDepth,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    d_ff_pipe_if.slave  bus
);

    localparam int unsigned TapW = tap_w(DEPTH);
    localparam int unsigned CntW = cnt_w(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             valid;
    } stage_t;

    stage_t            stage_in [DEPTH];
    stage_t            s_q      [DEPTH];
    stage_t            tap;
    logic              clr;
    logic [CntW-1:0]   count_d, count_q;

`ifdef D_FF_PIPE_CLR_EN
    assign clr = bus.clr;
`else
    assign clr = 1'b0;
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign stage_in[i] = '{data: bus.d, valid: bus.d_valid};
        end else begin : g_body
            assign stage_in[i] = s_q[i-1];
        end

        d_ff_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .en_i  (bus.en),
            .clr_i (clr),
            .d_i   (stage_in[i]),
            .q_o   (s_q[i])
        );
    end

    // Entry and exit on the same edge cancel, so the count stays within 0..DEPTH.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (bus.en) begin
            count_d = count_q + CntW'(bus.d_valid) - CntW'(s_q[DEPTH-1].valid);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Out-of-range selects fall through to the last stage.
    always_comb begin
        tap = s_q[DEPTH-1];
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (bus.tap_sel == TapW'(i)) begin
                tap = s_q[i];
            end
        end
    end

    assign bus.q         = s_q[DEPTH-1].data;
    assign bus.q_valid   = s_q[DEPTH-1].valid;
    assign bus.tap_q     = tap.data;
    assign bus.tap_valid = tap.valid;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_d_ff_pipe.sv
// Randomised and directed bench for d_ff_pipe against a history-queue reference model.
module tb_d_ff_pipe;

    localparam int unsigned Width  = 8;
    localparam int unsigned Depth  = 4;
    localparam logic [7:0]  RstVal = 8'h00;

    typedef struct {
        logic [7:0] d;
        logic       v;
    } ent_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    ent_t hist [$];

    d_ff_pipe_if #(.WIDTH(Width), .DEPTH(Depth)) bus ();

    d_ff_pipe #(
        .WIDTH   (Width),
        .DEPTH   (Depth),
        .RST_VAL (RstVal)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: newest accepted word sits at stage 0; stages not yet reached hold the reset word.
    function automatic ent_t model_stage(input int k);
        ent_t e;
        int   n;
        n = hist.size();
        if (k < n) begin
            e = hist[n-1-k];
        end else begin
            e.d = RstVal;
            e.v = 1'b0;
        end
        return e;
    endfunction

    function automatic int model_count();
        int c;
        c = 0;
        foreach (hist[i]) c += int'(hist[i].v);
        return c;
    endfunction

    always @(negedge rst_n) hist.delete();

    always @(posedge clk) begin
        if (rst_n) begin
`ifdef D_FF_PIPE_CLR_EN
            if (bus.clr) begin
                hist.delete();
            end else
`endif
            if (bus.en) begin
                hist.push_back('{d: bus.d, v: bus.d_valid});
                if (hist.size() > Depth) void'(hist.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        ent_t last, tp;
        int   ts;
        last = model_stage(Depth - 1);
        ts   = (int'(bus.tap_sel) >= Depth) ? Depth - 1 : int'(bus.tap_sel);
        tp   = model_stage(ts);
        chk("q",         32'(bus.q),         32'(last.d));
        chk("q_valid",   32'(bus.q_valid),   32'(last.v));
        chk("count",     32'(bus.count),     32'(model_count()));
        chk("tap_q",     32'(bus.tap_q),     32'(tp.d));
        chk("tap_valid", 32'(bus.tap_valid), 32'(tp.v));
    end

    // Inputs change just after the falling edge, away from both capture and sampling.
    task automatic step(input logic en, input logic [7:0] d, input logic dv, input logic [1:0] ts);
        #1;
        bus.en      = en;
        bus.d       = d;
        bus.d_valid = dv;
        bus.tap_sel = ts;
        @(negedge clk);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] words [4];
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        bus.en      = 1'b0;
        bus.d       = '0;
        bus.d_valid = 1'b0;
        bus.tap_sel = '0;
`ifdef D_FF_PIPE_CLR_EN
        bus.clr     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_q",         32'(bus.q),         32'h00);
        chk("rst_q_valid",   32'(bus.q_valid),   32'h0);
        chk("rst_count",     32'(bus.count),     32'h0);
        chk("rst_tap_valid", 32'(bus.tap_valid), 32'h0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);

        words = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) step(1'b1, words[i], 1'b1, 2'd0);
        chk("fill_q",       32'(bus.q),       32'h11);
        chk("fill_q_valid", 32'(bus.q_valid), 32'h1);
        chk("fill_count",   32'(bus.count),   32'h4);
        step(1'b1, 8'h00, 1'b0, 2'd0);
        chk("drain_q",     32'(bus.q),     32'h22);
        chk("drain_count", 32'(bus.count), 32'h3);

        do_reset();
        step(1'b1, 8'hA5, 1'b1, 2'd0);
        step(1'b1, 8'h5A, 1'b1, 2'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'hC3, 1'b1, 2'(i));
        chk("hold_count",   32'(bus.count),   32'h2);
        chk("hold_q_valid", 32'(bus.q_valid), 32'h0);
        #1;
        bus.tap_sel = 2'd1;
        #1;
        chk("hold_tap1", 32'(bus.tap_q), 32'hA5);
        bus.tap_sel = 2'd0;
        #1;
        chk("hold_tap0", 32'(bus.tap_q), 32'h5A);
        @(negedge clk);

        for (int i = 0; i < 2; i++) step(1'b1, 8'(8'h60 + i), 1'b1, 2'd3);
        chk("full_count", 32'(bus.count), 32'h4);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_q",       32'(bus.q),       32'h00);
        chk("async_q_valid", 32'(bus.q_valid), 32'h0);
        chk("async_count",   32'(bus.count),   32'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) step(1'b1, 8'($urandom), 1'(~i[0]), 2'(i));
        chk("alt_count", 32'(bus.count), 32'h2);

`ifdef D_FF_PIPE_CLR_EN
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h70 + i), 1'b1, 2'd0);
        chk("pre_clr_count", 32'(bus.count), 32'h3);
        #1;
        bus.clr = 1'b1;
        step(1'b1, 8'hFF, 1'b1, 2'd0);
        #1;
        bus.clr = 1'b0;
        chk("clr_count", 32'(bus.count), 32'h0);
        for (int i = 0; i < 4; i++) begin
            bus.tap_sel = 2'(i);
            #1;
            chk("clr_tap_valid", 32'(bus.tap_valid), 32'h0);
        end
        @(negedge clk);
`endif

        for (int i = 0; i < 400; i++) begin
`ifdef D_FF_PIPE_CLR_EN
            #1;
            bus.clr = ($urandom_range(0, 19) == 0);
`endif
            step(($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom), 2'($urandom));
            if ($urandom_range(0, 99) == 0) begin
                #2;
                rst_n = 1'b0;
                @(negedge clk);
                #1;
                rst_n = 1'b1;
                @(negedge clk);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
